// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Function : Responder for load/store requests. Each access is executed one
//            byte at a time on a byte-wide RAM port. Load results are sign- or
//            zero-extended and returned with a one-cycle ready pulse.
// Option   : define DATA_MEM_CTRL_IO_STALL_EN to hold store bytes aimed at
//            the I/O window (addr >= IO_BASE) while io_buffer_full is high.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic [2:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_value,
  output logic                  ready,
  output logic [31:0]           res,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_wr;
  logic [2:0]            r_size;
  logic [31:0]           r_addr;
  logic [31:0]           r_value;
  logic [31:0]           r_res;
  logic [1:0]            r_k;
  logic [7:0]            r_skid;
  logic                  r_paused;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;

  logic [1:0]            w_last_k;
  logic [1:0]            w_k_nxt;
  logic [31:0]           w_addr_k;
  logic [31:0]           w_addr_nxt;
  logic                  w_stall;
  logic [1:0]            w_cap_idx;
  logic [7:0]            w_din;
  logic [31:0]           w_res_cap;
  logic                  w_sign;
  logic [31:0]           w_res_ext;

  // Index of the final byte: 0, 1 or 3 (size 3 behaves as a word)
  assign w_last_k   = (r_size[1:0] == 2'd0) ? 2'd0 :
                      (r_size[1:0] == 2'd1) ? 2'd1 : 2'd3;
  assign w_k_nxt    = r_k + 2'd1;
  assign w_addr_k   = r_addr + {30'd0, r_k};
  assign w_addr_nxt = w_addr_k + 32'd1;

`ifdef DATA_MEM_CTRL_IO_STALL_EN
  // A store byte into the I/O window waits for room in the I/O sink
  assign w_stall = r_wr && io_buffer_full && (w_addr_k >= IO_BASE);
`else
  logic w_unused;
  assign w_stall  = 1'b0;
  assign w_unused = ^{io_buffer_full, IO_BASE};
`endif

  // Byte returned for index k-1 while accessing, index n-1 while draining.
  // After a pause the live RAM data has moved on, so the skid byte is used.
  assign w_cap_idx = (r_state == ST_DRAIN) ? r_k : (r_k - 2'd1);
  assign w_din     = r_paused ? r_skid : mem_din;

  // Merge the returning byte into the partial result
  always_comb begin
    w_res_cap = r_res;
    w_res_cap[{w_cap_idx, 3'b000} +: 8] = w_din;
  end

  // Extend the assembled load from bit 8n-1
  always_comb begin
    w_sign = 1'b0;
    case (r_size[1:0])
      2'd0:    w_sign = r_res[7];
      2'd1:    w_sign = r_res[15];
      default: w_sign = r_res[31];
    endcase
    if (r_size[2]) w_sign = 1'b0;
    case (r_size[1:0])
      2'd0:    w_res_ext = {{24{w_sign}}, r_res[7:0]};
      2'd1:    w_res_ext = {{16{w_sign}}, r_res[15:0]};
      default: w_res_ext = r_res;
    endcase
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state decode, write strobe and completion outputs
  always_comb begin
    w_state_nxt = r_state;
    mem_wr      = 1'b0;
    ready       = 1'b0;
    res         = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (rdy_in && req_valid) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_wr = r_wr && rdy_in && !w_stall;
        if (rdy_in && !w_stall && (r_k == w_last_k))
          w_state_nxt = r_wr ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rdy_in) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        ready = 1'b1;
        if (!r_wr) res = w_res_ext;
        if (rdy_in) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, byte index, RAM address/data registers and load capture
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr       <= 1'b0;
      r_size     <= 3'd0;
      r_addr     <= 32'd0;
      r_value    <= 32'd0;
      r_res      <= 32'd0;
      r_k        <= 2'd0;
      r_skid     <= 8'd0;
      r_paused   <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
    end else begin
      r_paused <= !rdy_in;
      if (!rdy_in && !r_paused) r_skid <= mem_din;
      if (rdy_in) begin
        case (r_state)
          ST_IDLE: begin
            if (req_valid) begin
              r_wr    <= req_wr;
              r_size  <= req_size;
              r_addr  <= req_addr;
              r_value <= req_value;
              r_res   <= 32'd0;
              r_k     <= 2'd0;
              r_mem_a <= req_addr[ADDR_WIDTH-1:0];
              if (req_wr) r_mem_dout <= req_value[7:0];
            end
          end
          ST_ACCESS: begin
            if (!w_stall) begin
              if (!r_wr && (r_k != 2'd0)) r_res <= w_res_cap;
              if (r_k != w_last_k) begin
                r_k     <= w_k_nxt;
                r_mem_a <= w_addr_nxt[ADDR_WIDTH-1:0];
                if (r_wr) r_mem_dout <= r_value[{w_k_nxt, 3'b000} +: 8];
              end
            end
          end
          ST_DRAIN: r_res <= w_res_cap;
          default: ;
        endcase
      end
    end
  end

  assign mem_a    = r_mem_a;
  assign mem_dout = r_mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Function : Directed self-checking bench for data_mem_ctrl with a byte RAM
//            model of one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        req_valid;
  logic        req_wr;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_value;
  logic        ready;
  logic [31:0] res;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ram [0:4095];
  int          wr_cnt;
  int          wr_cyc  [0:7];
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  logic [31:0] a_log   [0:7];
  int          rc;
  logic [31:0] rr;
  int          nrdy;

  data_mem_ctrl #(.ADDR_WIDTH(32), .IO_BASE(32'h30000)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_value(req_value), .ready(ready), .res(res),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Byte RAM: registered read, write on strobe
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One request; cycle 0 is the accept cycle. Inputs change 1 time unit after
  // the rising edge, outputs are sampled on the falling edge.
  task automatic run_req(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] value, input int p_start, input int p_len,
                         input int io_start, input int io_len, input bit keep,
                         output int rdy_cyc, output logic [31:0] rdy_res);
    bit active;
    rdy_cyc = -1;
    rdy_res = 32'd0;
    wr_cnt  = 0;
    active  = 1'b1;
    for (int c = 0; c < 40 && active; c++) begin
      @(posedge clk_in); #1;
      if (c == 0) begin
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_addr  = addr;
        req_value = value;
      end
      rdy_in         = !(c >= p_start && c < p_start + p_len);
      io_buffer_full = (c >= io_start && c < io_start + io_len);
      @(negedge clk_in);
      if (c < 8) a_log[c] = mem_a;
      if (mem_wr && wr_cnt < 8) begin
        wr_cyc[wr_cnt]  = c;
        wr_addr[wr_cnt] = mem_a;
        wr_data[wr_cnt] = {24'd0, mem_dout};
        wr_cnt++;
      end
      if (ready) begin
        rdy_cyc = c;
        rdy_res = res;
        active  = 1'b0;
        if (!keep) req_valid = 1'b0;
      end
    end
    if (rdy_cyc < 0) req_valid = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
    req_size = 3'd0; req_addr = 32'd0; req_value = 32'd0; io_buffer_full = 1'b0;
    #2;
    check_val("rst_ready", {31'd0, ready}, 32'd0);
    check_val("rst_res", res, 32'd0);
    check_val("rst_mem_a", mem_a, 32'd0);
    check_val("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check_val("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    // SW 0x100 = 0x44332211: four writes, ready at cycle 5
    run_req(1'b1, 3'd2, 32'h100, 32'h44332211, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("sw_rdy_cyc", rc, 32'd5);
    check_val("sw_wr_cnt", wr_cnt, 32'd4);
    check_val("sw_wr3_addr", wr_addr[3], 32'h103);
    check_val("sw_wr3_data", wr_data[3], 32'h44);
    check_val("sw_res", rr, 32'd0);

    // LW 0x100: addresses in cycles 1-4, ready at cycle 6
    run_req(1'b0, 3'd2, 32'h100, 32'd0, 99, 0, 99, 0, 1'b0, rc, rr);
    for (int i = 1; i <= 4; i++)
      check_val($sformatf("lw_mem_a_c%0d", i), a_log[i], 32'h100 + i - 1);
    check_val("lw_rdy_cyc", rc, 32'd6);
    check_val("lw_res", rr, 32'h44332211);
    check_val("lw_wr_cnt", wr_cnt, 32'd0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check_val("lw_ready_width", {31'd0, ready}, 32'd0);

    // LB / LBU of byte 0x80
    run_req(1'b1, 3'd0, 32'h150, 32'hFFFFFF80, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("sb_rdy_cyc", rc, 32'd2);
    run_req(1'b0, 3'd0, 32'h150, 32'd0, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("lb_res", rr, 32'hFFFFFF80);
    check_val("lb_rdy_cyc", rc, 32'd3);
    run_req(1'b0, 3'd4, 32'h150, 32'd0, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("lbu_res", rr, 32'h00000080);
    check_val("lbu_rdy_cyc", rc, 32'd3);

    // SH 0x1FF = 0xABCD (misaligned, crosses 0x200)
    run_req(1'b1, 3'd1, 32'h1FF, 32'h0000ABCD, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("sh_wr_cnt", wr_cnt, 32'd2);
    check_val("sh_wr0_addr", wr_addr[0], 32'h1FF);
    check_val("sh_wr0_data", wr_data[0], 32'hCD);
    check_val("sh_wr0_cyc", wr_cyc[0], 32'd1);
    check_val("sh_wr1_addr", wr_addr[1], 32'h200);
    check_val("sh_wr1_data", wr_data[1], 32'hAB);
    check_val("sh_rdy_cyc", rc, 32'd3);
    check_val("sh_res", rr, 32'd0);
    run_req(1'b0, 3'd1, 32'h1FF, 32'd0, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("lh_res", rr, 32'hFFFFABCD);
    run_req(1'b0, 3'd5, 32'h1FF, 32'd0, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("lhu_res", rr, 32'h0000ABCD);

    // Back-to-back: req_valid stays high through ready
    run_req(1'b1, 3'd2, 32'h300, 32'h12345678, 99, 0, 99, 0, 1'b1, rc, rr);
    check_val("b2b_first_rdy", rc, 32'd5);
    run_req(1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("b2b_second_rdy", rc, 32'd5);
    check_val("b2b_wr_cnt", wr_cnt, 32'd4);
    check_val("b2b_wr0_cyc", wr_cyc[0], 32'd1);
    check_val("b2b_wr0_addr", wr_addr[0], 32'h400);
    check_val("b2b_wr0_data", wr_data[0], 32'h0D);
    run_req(1'b0, 3'd2, 32'h300, 32'd0, 99, 0, 99, 0, 1'b0, rc, rr);
    check_val("b2b_lw_res", rr, 32'h12345678);

    // LW with rdy_in low in cycles 3-5
    run_req(1'b0, 3'd2, 32'h100, 32'd0, 3, 3, 99, 0, 1'b0, rc, rr);
    check_val("pause_lw_res", rr, 32'h44332211);
    check_val("pause_lw_rdy", rc, 32'd9);
    check_val("pause_lw_wr_cnt", wr_cnt, 32'd0);

    // SB with rdy_in low in cycles 1-2: no write until resumed
    run_req(1'b1, 3'd0, 32'h600, 32'h0000005A, 1, 2, 99, 0, 1'b0, rc, rr);
    check_val("pause_sb_wr_cnt", wr_cnt, 32'd1);
    check_val("pause_sb_wr_cyc", wr_cyc[0], 32'd3);
    check_val("pause_sb_rdy", rc, 32'd4);

    // SB into the I/O window with the sink full in cycles 1-4
    run_req(1'b1, 3'd0, 32'h30000, 32'h000000E7, 99, 0, 1, 4, 1'b0, rc, rr);
    check_val("io_wr_cnt", wr_cnt, 32'd1);
    check_val("io_wr_data", wr_data[0], 32'hE7);
`ifdef DATA_MEM_CTRL_IO_STALL_EN
    check_val("io_wr_cyc", wr_cyc[0], 32'd5);
    check_val("io_rdy_cyc", rc, 32'd6);
`else
    check_val("io_wr_cyc", wr_cyc[0], 32'd1);
    check_val("io_rdy_cyc", rc, 32'd2);
`endif

    // Reset in the middle of a LW
    @(posedge clk_in); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_size = 3'd2; req_addr = 32'h100;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check_val("mid_pre_mem_a", mem_a, 32'h101);
    rst_n_in = 1'b0;
    #1;
    check_val("mid_ready", {31'd0, ready}, 32'd0);
    check_val("mid_res", res, 32'd0);
    check_val("mid_mem_a", mem_a, 32'd0);
    check_val("mid_mem_dout", {24'd0, mem_dout}, 32'd0);
    check_val("mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    nrdy = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (ready) nrdy++;
    end
    check_val("mid_no_ready", nrdy, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Responder side of the load/store-to-cache request interface.
- Accepts one load or store from the load/store buffer and executes it byte-serially on the byte-wide RAM port.
- Sign- or zero-extends load data and returns completion as a single-cycle ready pulse with the result.
- Sits between the load/store buffer and the memory arbiter/RAM.

Parameters:
- ADDR_WIDTH, 32, width of mem_a; the low bits of the request address are driven.
- IO_BASE, 32'h30000, first address of the I/O window; used only with the optional feature.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low pauses the block
- req_valid  input  1  request present; held high until ready
- req_wr  input  1  1 = store, 0 = load
- req_size  input  3  [1:0]: 0 byte, 1 half, 2 word; [2]: 1 = zero-extend, 0 = sign-extend (loads only)
- req_addr  input  32  byte address
- req_value  input  32  store data, little-endian
- ready  output  1  one-cycle completion pulse
- res  output  32  load result, valid while ready=1
- mem_din  input  8  RAM read byte, one-cycle latency
- mem_dout  output  8  RAM write byte
- mem_a  output  ADDR_WIDTH  RAM byte address
- mem_wr  output  1  RAM write strobe
- io_buffer_full  input  1  I/O sink full

Behaviour:
- Reset (async, rst_n_in=0):
  - All outputs go to 0 immediately: ready, res, mem_dout, mem_a, mem_wr.
  - FSM goes to IDLE; any in-flight request is aborted and never acknowledged.
- FSM states: IDLE, ACCESS, DRAIN, DONE.
- Byte count n = 1/2/4 for size 0/1/2. Size 3 is treated as word.
- IDLE:
  - Sample req_valid. If high, latch wr/size/addr/value, set byte index k=0, go to ACCESS.
  - Cycle numbering below: cycle 0 = the accept cycle.
- ACCESS:
  - In cycle k+1, drive mem_a = addr+k (32-bit wrap, truncated to ADDR_WIDTH).
  - Stores also drive mem_dout = value[8k+7:8k] and mem_wr=1.
  - k increments each cycle. After byte n-1: stores go to DONE, loads go to DRAIN.
- Load data: mem_din in cycle k+2 holds byte k; it is captured into res[8k+7:8k] at the end of that cycle. DRAIN covers the final byte's return cycle.
- DONE:
  - ready=1 for exactly one cycle, then return to IDLE.
  - Completion cycle: stores at cycle n+1, loads at cycle n+2.
  - res = captured bytes extended from bit 8n-1 per req_size[2]. Stores return res=0.
- No accept happens in the DONE cycle even if req_valid is high: the requester still shows the old request then. Earliest next accept is the cycle after ready.
- mem_wr is 0 in every state other than ACCESS-store. mem_a and mem_dout hold their last values when idle.
- A drop of req_valid mid-operation is ignored; the latched request completes.
- Misaligned addresses are legal; bytes are simply addr, addr+1, and so on.
- rdy_in=0:
  - All FSM, index and capture state is frozen. mem_wr is forced 0 combinationally; ready, if high, is held.
  - A one-byte skid register samples mem_din in the first paused cycle. After resume it supplies the in-flight load byte, so no byte is lost.

Optional Feature:
- Macro: DATA_MEM_CTRL_IO_STALL_EN.
- Defined: a store byte with addr+k >= IO_BASE is not issued while io_buffer_full=1. mem_wr stays 0 and k holds; the byte is issued in the first cycle io_buffer_full=0. Loads are unaffected.
- Undefined: io_buffer_full is ignored.

Test Plan:
- LW addr=0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 in cycles 1-4; ready in cycle 6 only; res=0x44332211.
- LB (size 0) at a byte 0x80 -> res=0xFFFFFF80. LBU (size 4) at the same byte -> res=0x00000080. Both ready at cycle 3.
- SH addr=0x1FF, value=0xABCD -> mem_wr=1 with (0x1FF, CD) then (0x200, AB); ready in cycle 3; res=0.
- Back-to-back: req_valid held high across ready with a new SW -> no accept in the ready cycle; the second accept is in the cycle after ready.
- LW with rdy_in=0 for 3 cycles starting at cycle 3 -> res is still correct, ready is delayed by 3, and mem_wr stays 0 throughout.
- SB to 0x30000 with DATA_MEM_CTRL_IO_STALL_EN and io_buffer_full=1 for 4 cycles -> mem_wr stays 0 for those cycles, then one write; ready follows one cycle later. Separately, rst_n_in low mid-LW -> all outputs 0 immediately and no ready ever for that load.
